fir_decim_buffer: RTL and testbench
===================================

# fir_decim_buffer

Downstream stage of `fir_16tap`. It takes the filter's free-running Q1.15 output stream (one sample per clock, no valid) and discards the samples produced while the filter pipeline fills. It keeps every DECIM-th sample after that and buffers the kept samples in a small FIFO. The FIFO presents them to the consumer over a valid/ready handshake, and the block counts samples dropped to backpressure.

## Interface
- `DECIM`, 4: decimation factor; 1 = keep every sample; range 1..256.
- `DEPTH`, 8: FIFO depth in samples; power of two, ≥2.
- `SKIP`, 8: samples discarded after reset; matches FIR latency; range 0..255.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `y_in`  in  16  signed Q1.15 sample from `fir_16tap.y_out`; sampled every edge.
- `m_data`  out  16  signed Q1.15 FIFO head; 0 when `m_valid`=0.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  consumer accepts head when high with `m_valid`.
- `level`  out  $clog2(DEPTH)+1  number of samples stored.
- `overflow`  out  1  sticky; set on first dropped sample, cleared only by reset.
- `drop_cnt`  out  8  dropped-sample count, saturates at 255.

## Operation
- Edge numbering: edge k is the k-th rising edge with `rst` low since the last edge that sampled `rst` high.
- Skip phase: the samples at edges 1..SKIP are ignored. The skip counter stops at SKIP and does not change again until reset.
- Decimation: a phase counter runs 0..DECIM-1 and wraps to 0; it starts after the skip phase. The sample at edge SKIP+1+n·DECIM (n ≥ 0) is a capture. No other samples are stored.
- Pop: occurs on any edge where `m_valid`=1 and `m_ready`=1. The read pointer advances modulo DEPTH.
- Push on a capture:
  - If `level` < DEPTH, or a pop occurs on the same edge, `y_in` is written at the write pointer and the write pointer advances modulo DEPTH.
  - Otherwise the sample is dropped: `overflow` is set to 1 and `drop_cnt` is incremented unless it is already 255.
- `level` update: +1 on push only, −1 on pop only, unchanged on push+pop or on neither.
- Full push+pop: a push and pop on the same edge while `level`=DEPTH is legal. The old head leaves, the new sample enters at the tail, `level` stays DEPTH and nothing is dropped.
- Empty pop: impossible, because `m_valid`=0 blocks it. `m_ready` is ignored while `m_valid`=0.
- Data path: no arithmetic on samples. Data is stored and forwarded bit-exact and in order.
- `m_data` is first-word fall-through: storage[read pointer], gated to 0 when empty.
- Mid-operation reset discards all stored samples, restarts the skip phase, and clears `overflow` and `drop_cnt`.

## Timing
- Reset values (after an edge with `rst`=1): `m_valid`=0, `m_data`=0, `level`=0, `overflow`=0, `drop_cnt`=0. All pointers and counters are 0.
- Capture-to-output latency: 1 cycle. A sample captured at edge k into an empty FIFO appears on `m_data` with `m_valid`=1 right after edge k and is poppable at edge k+1.
- With `m_ready` held at 1, each kept sample is valid for exactly one cycle. `m_valid` is high 1 of every DECIM cycles (continuously high when DECIM=1).
- `overflow`, `drop_cnt` and `level` update on the same edge as the push/drop/pop that causes them.
- `m_valid` and `m_data` depend only on registered state. There is no combinational path from `m_ready` or `y_in` to any output.
- `rst` takes priority over a push or pop on the same edge.
- End-to-end: with FIR latency 8 and SKIP=8, the first kept sample is the first valid FIR output.

## Test plan
- **Reset hold:** `rst`=1 for 5 cycles with random `y_in` and `m_ready`=1 → `m_valid`=0, `m_data`=0, `level`=0, `overflow`=0, `drop_cnt`=0 on every cycle.
- **Skip/decimate:** DECIM=4, SKIP=8, `m_ready`=1, `y_in` = edge index k → outputs are 9, 13, 17, 21, …. Each is valid for one cycle, starting the cycle after its capture edge, and `level` is never above 1.
- **Backpressure and overflow:** `m_ready`=0 with `y_in`=k →
  - after captures 9..37 (8 samples), `level`=8;
  - the capture at edge 41 is dropped: `overflow`=1, `drop_cnt`=1;
  - then `m_ready`=1 → drain yields 9, 13, …, 37 in order, ending with `level`=0 and `overflow` still 1.
- **Full push+pop:** `level`=8, `m_ready`=1 on a capture edge → `level` stays 8, `drop_cnt` is unchanged, the head advances, and the new sample is the last one drained.
- **Saturation:** `m_ready`=0 for more than (8+260)·DECIM cycles → `drop_cnt` reaches 255 and holds. `overflow` stays 1 and `level` stays 8.
- **Mid-op reset:** assert `rst` for 1 edge with `level`=5 → the next cycle shows `level`=0, `m_valid`=0, `drop_cnt`=0. The first post-reset output is the sample at new edge 9.

Source files
------------

// File: rtl/fir_decim_buffer.sv
// fir_decim_buffer: skip FIR fill samples, keep every DECIM-th, buffer in a FWFT FIFO with drop accounting
module fir_decim_buffer #(
    parameter int DECIM = 4,
    parameter int DEPTH = 8,
    parameter int SKIP  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [15:0]      y_in,
    output logic signed [15:0]      m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [7:0]              drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0] SKIP_V = 8'(SKIP);
    localparam logic [7:0] PH_MAX = 8'(DECIM - 1);
    localparam logic [LW-1:0] FULL_V = LW'(DEPTH);

    logic [7:0]          r_skip;
    logic [7:0]          r_phase;
    logic [AW-1:0]       r_wr;
    logic [AW-1:0]       r_rd;
    logic [LW-1:0]       r_level;
    logic                r_ovf;
    logic [7:0]          r_drop;
    logic signed [15:0]  r_mem [DEPTH];

    logic w_run;
    logic w_cap;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;

    assign w_run  = (r_skip == SKIP_V);
    assign w_cap  = w_run && (r_phase == 8'd0);
    assign w_pop  = m_valid && m_ready;
    assign w_full = (r_level == FULL_V);
    assign w_push = w_cap && (!w_full || w_pop);
    assign w_drop = w_cap && w_full && !w_pop;

    assign m_valid  = (r_level != '0);
    assign m_data   = m_valid ? r_mem[r_rd] : '0;
    assign level    = r_level;
    assign overflow = r_ovf;
    assign drop_cnt = r_drop;

    // skip counter saturates at SKIP, then the decimation phase free-runs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skip  <= '0;
            r_phase <= '0;
        end else if (!w_run) begin
            r_skip <= r_skip + 8'd1;
        end else begin
            r_phase <= (r_phase == PH_MAX) ? 8'd0 : r_phase + 8'd1;
        end
    end

    // FIFO pointers, occupancy and sticky drop accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            end
        end
    end

    // sample storage; contents are don't-care while empty since m_data is gated
    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wr] <= y_in;
    end
endmodule

// File: tb/tb_fir_decim_buffer.sv
// tb_fir_decim_buffer: directed checks of skip, decimation, backpressure, saturation and reset
module tb_fir_decim_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_ready = 1'b1;
    logic signed [15:0] y_in = '0;
    logic signed [15:0] m_data;
    logic m_valid;
    logic [3:0] level;
    logic overflow;
    logic [7:0] drop_cnt;
    int n_chk = 0;
    int n_fail = 0;
    int k = 0;
    logic v;
    int exp_d [11] = '{13, 17, 21, 25, 29, 33, 37, 45, 49, 53, 0};
    int exp_l [11] = '{8, 7, 6, 5, 5, 4, 3, 2, 2, 1, 0};

    fir_decim_buffer #(.DECIM(4), .DEPTH(8), .SKIP(8)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int ev, input int ed, input int el, input int eo, input int ec);
        chk({tag, "_valid"}, 32'(m_valid), ev);
        chk({tag, "_data"}, 32'(m_data), ed);
        chk({tag, "_level"}, 32'(level), el);
        chk({tag, "_ovf"}, 32'(overflow), eo);
        chk({tag, "_drop"}, 32'(drop_cnt), ec);
    endtask

    task automatic tick();
        y_in = 16'(k + 1);
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        y_in = 16'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
    endtask

    initial begin
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            y_in = 16'($urandom);
            @(posedge clk);
            #1;
            chk_state("rst_hold", 0, 0, 0, 0, 0);
        end
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            v = (k >= 9) && ((k - 9) % 4 == 0);
            chk("skip_valid", 32'(m_valid), 32'(v));
            chk("skip_data", 32'(m_data), v ? k : 0);
            chk("skip_level", 32'(level), 32'(v));
        end
        rst_pulse();
        m_ready = 1'b0;
        repeat (36) tick();
        chk("bp_level36", 32'(level), 7);
        tick();
        chk_state("bp_full37", 1, 9, 8, 0, 0);
        repeat (3) tick();
        chk("bp_ovf40", 32'(overflow), 0);
        tick();
        chk_state("bp_drop41", 1, 9, 8, 1, 1);
        repeat (3) tick();
        chk_state("bp_hold44", 1, 9, 8, 1, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk($sformatf("drain_data_e%0d", k), 32'(m_data), exp_d[i]);
            chk($sformatf("drain_level_e%0d", k), 32'(level), exp_l[i]);
            chk($sformatf("drain_drop_e%0d", k), 32'(drop_cnt), 1);
        end
        chk_state("drain_end", 0, 0, 0, 1, 1);
        rst_pulse();
        m_ready = 1'b0;
        repeat (1056) tick();
        chk("sat_drop254", 32'(drop_cnt), 254);
        tick();
        chk("sat_drop255", 32'(drop_cnt), 255);
        repeat (100) tick();
        chk_state("sat_hold", 1, 9, 8, 1, 255);
        rst_pulse();
        chk_state("sat_reset", 0, 0, 0, 0, 0);
        repeat (25) tick();
        chk("mid_level5", 32'(level), 5);
        chk("mid_head", 32'(m_data), 9);
        rst_pulse();
        chk_state("mid_reset", 0, 0, 0, 0, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("mid_skip_e%0d", k), 32'(m_valid), 0);
        end
        tick();
        chk_state("mid_first", 1, 9, 1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
